// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   EX-stage multiply/divide unit for MULT, MULTU, DIV and DIVU. Uses an
//   iterative shift-add multiplier and a restoring divider, one bit per
//   cycle. Results are written to the HI/LO registers. While an operation is
//   in flight the unit holds the front end, and it serves MFHI/MFLO reads.
//
// Ports
//   clock       system clock; all state changes on the rising edge
//   reset       synchronous, active-low
//   EX_start    a mul/div operation is presented this cycle
//   EX_op       00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   EX_D1       rs operand (multiplicand / dividend)
//   EX_D2       rt operand (multiplier / divisor)
//   EX_hilo_rd  MFHI/MFLO is in EX this cycle
//   EX_flush    squash the in-flight operation
//   HI, LO      product high/low, or remainder/quotient
//   busy        unit is not idle
//   stall       hold IF/ID and ID/EX this cycle
//   done        one-cycle pulse in the cycle HI/LO were updated
//   div0        sticky: last completed operation divided by zero
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             EX_start,
  input  logic [1:0]       EX_op,
  input  logic [WIDTH-1:0] EX_D1,
  input  logic [WIDTH-1:0] EX_D2,
  input  logic             EX_hilo_rd,
  input  logic             EX_flush,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div0
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             s1_q, s1_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div0_q, div0_d;

  logic             in_s1, in_s2;
  logic [WIDTH-1:0] in_abs1, in_abs2;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  // Operand magnitudes. Only the signed ops (EX_op[0]) take absolute values.
  assign in_s1   = EX_op[0] & EX_D1[WIDTH-1];
  assign in_s2   = EX_op[0] & EX_D2[WIDTH-1];
  assign in_abs1 = in_s1 ? -EX_D1 : EX_D1;
  assign in_abs2 = in_s2 ? -EX_D2 : EX_D2;

  // Multiply step. {acc, work} is the product register. The multiplier shifts
  // out of work's LSB, and the low product bits shift in from the top.
  assign mul_sum = {1'b0, acc_q} + (work_q[0] ? {1'b0, opb_q} : '0);

  // Restoring divide step. The dividend shifts out of work's MSB into the
  // remainder, and quotient bits shift into work's LSB. When the subtract
  // succeeds, the new remainder is below the divisor, so the low WIDTH bits of
  // the difference are exact.
  assign div_shift = {acc_q, work_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  assign div_rem   = div_shift[WIDTH-1:0] - opb_q;

  // Sign correction. For a zero divisor the quotient is forced to all ones.
  // The remainder then holds |dividend|, and applying the dividend's sign
  // restores the original rs value.
  assign prod     = {acc_q, work_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quot_fix = dz_q ? '1 : (neg_q ? -work_q : work_q);
  assign rem_fix  = s1_q ? -acc_q : acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    work_d   = work_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    s1_d     = s1_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div0_d   = div0_q;

    case (state_q)
      // A new op can start from IDLE or DONE. If a flush arrives in the
      // same cycle, the flush wins.
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (!EX_flush && EX_start) begin
          state_d  = S_RUN;
          cnt_d    = CNT_LAST;
          acc_d    = '0;
          is_div_d = EX_op[1];
          neg_d    = in_s1 ^ in_s2;
          s1_d     = in_s1;
          dz_d     = EX_op[1] && (EX_D2 == '0);
          work_d   = EX_op[1] ? in_abs1 : in_abs2;
          opb_d    = EX_op[1] ? in_abs2 : in_abs1;
        end
      end
      S_RUN: begin
        if (EX_flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            acc_d  = div_ge ? div_rem : div_shift[WIDTH-1:0];
            work_d = {work_q[WIDTH-2:0], div_ge};
          end else begin
            acc_d  = mul_sum[WIDTH:1];
            work_d = {mul_sum[0], work_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        if (EX_flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          div0_d  = dz_q;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      work_q   <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      s1_q     <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      work_q   <= work_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      s1_q     <= s1_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      div0_q   <= div0_d;
    end
  end

  assign HI    = hi_q;
  assign LO    = lo_q;
  assign div0  = div0_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  // A flushed cycle never stalls: the squashed instruction is leaving anyway.
  assign stall = ((state_q == S_RUN) || (state_q == S_FIX)) &&
                 (EX_start || EX_hilo_rd) && !EX_flush;

endmodule
